// File: rtl/ppu_pkg.sv
// Shared posit types, constants and helpers for the operand front end.
// posit_t is sized for the widest supported posit (N <= 64); narrower users pass their width.
package ppu_pkg;

    localparam int MAX_N = 64;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_FMA = 3'd4,
        OP_F2P = 3'd5
    } operation_e;

    typedef logic [MAX_N-1:0] posit_t;

    localparam posit_t ZERO = '0;

    // NAR for an n-bit posit: a single 1 in the sign position.
    function automatic posit_t nar(input int n);
        return posit_t'(1) << (n - 1);
    endfunction

    function automatic posit_t width_mask(input int n);
        return (n >= MAX_N) ? '1 : ((posit_t'(1) << n) - posit_t'(1));
    endfunction

    // Two's complement negation modulo 2^n.
    function automatic posit_t c2(input posit_t x, input int n);
        return (~x + posit_t'(1)) & width_mask(n);
    endfunction

    // Two's complement magnitude; NAR maps onto itself, the largest magnitude.
    function automatic posit_t posit_abs(input posit_t x, input int n);
        return ((x & nar(n)) != ZERO) ? c2(x, n) : x;
    endfunction

endpackage

// File: rtl/operand_classify.sv
// Combinational operand conditioning: SUB->ADD rewrite, magnitude ordering for
// ADD, and detection of special/trivial results that bypass the datapath.
module operand_classify
    import ppu_pkg::*;
#(
    parameter int N = 16
) (
    input  operation_e     op,
    input  logic [N-1:0]   p1,
    input  logic [N-1:0]   p2,
    input  logic [N-1:0]   p3,
    output operation_e     op_c,
    output logic [N-1:0]   p1_c,
    output logic [N-1:0]   p2_c,
    output logic [N-1:0]   p3_c,
    output logic           special,
    output logic [N-1:0]   special_bits
);

    localparam logic [N-1:0] NAR_N = {1'b1, {(N-1){1'b0}}};

    posit_t a1, a2, a3, n2;
    logic   is_sub, addsub, swap;
    logic   z1, z2, nar1, nar2, nar3;

    always_comb begin
        a1     = posit_t'(p1);
        a2     = posit_t'(p2);
        a3     = posit_t'(p3);
        is_sub = (op == OP_SUB);
        addsub = (op == OP_ADD) || is_sub;
        n2     = is_sub ? c2(a2, N) : a2;
        swap   = addsub && (posit_abs(n2, N) > posit_abs(a1, N));

        op_c = is_sub ? OP_ADD : op;
        p1_c = swap ? n2[N-1:0] : p1;
        p2_c = addsub ? (swap ? p1 : n2[N-1:0]) : p2;
        p3_c = p3;

        z1   = (a1 == ZERO);
        z2   = (a2 == ZERO);
        nar1 = (a1 == nar(N));
        nar2 = (a2 == nar(N));
        nar3 = (a3 == nar(N));

        // Priority chain: the first rule that matches decides the result.
        special      = 1'b0;
        special_bits = '0;
        if (op == OP_F2P) begin
            special = 1'b0;
        end else if (nar1 || nar2 || (op == OP_FMA && nar3)) begin
            special      = 1'b1;
            special_bits = NAR_N;
        end else if (op == OP_DIV && z2) begin
            special      = 1'b1;
            special_bits = NAR_N;
        end else if (((op == OP_MUL || op == OP_DIV) && z1) || (op == OP_MUL && z2)) begin
            special = 1'b1;
        end else if (op == OP_FMA && (z1 || z2)) begin
            special      = 1'b1;
            special_bits = p3;
        end else if (addsub && z1) begin
            special      = 1'b1;
            special_bits = n2[N-1:0];
        end else if (addsub && z2) begin
            special      = 1'b1;
            special_bits = p1;
        end else if (addsub && (a1 == c2(n2, N))) begin
            special = 1'b1;
        end
    end

endmodule

// File: rtl/operand_conditioner.sv
// Operand conditioning stage with one-cycle latency, an optional two-entry skid
// buffer and a saturating count of special results accepted.
module operand_conditioner
    import ppu_pkg::*;
#(
    parameter int N    = 16,
    parameter int SKID = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  operation_e     op_i,
    input  logic [N-1:0]   p1_i,
    input  logic [N-1:0]   p2_i,
    input  logic [N-1:0]   p3_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output operation_e     op_o,
    output logic [N-1:0]   p1_o,
    output logic [N-1:0]   p2_o,
    output logic [N-1:0]   p3_o,
    output logic           special_tag_o,
    output logic [N-1:0]   special_bits_o,
    output logic [15:0]    special_cnt_o
);

    typedef struct packed {
        operation_e   op;
        logic [N-1:0] p1;
        logic [N-1:0] p2;
        logic [N-1:0] p3;
        logic         tag;
        logic [N-1:0] bits;
    } set_t;

    set_t        in_set, main_q, skid_q;
    logic        main_v, skid_v;
    logic        push, pop;
    logic [15:0] cnt_q;

    operand_classify #(.N(N)) u_classify (
        .op           (op_i),
        .p1           (p1_i),
        .p2           (p2_i),
        .p3           (p3_i),
        .op_c         (in_set.op),
        .p1_c         (in_set.p1),
        .p2_c         (in_set.p2),
        .p3_c         (in_set.p3),
        .special      (in_set.tag),
        .special_bits (in_set.bits)
    );

    // Handshake: a set moves on a side only in a cycle where valid and ready are
    // both high; ready never depends on in_valid_i, and a presented output holds
    // unchanged until it is taken.
    always_comb begin
        if (SKID != 0) in_ready_o = ~main_v | out_ready_i | ~skid_v;
        else           in_ready_o = ~main_v | out_ready_i;
        push = in_valid_i & in_ready_o;
        pop  = main_v & out_ready_i;
    end

    // The skid slot only fills when main is held; with SKID=0 ready blocks that case.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (pop) begin
                if (skid_v) begin
                    main_q <= skid_q;
                    if (push) skid_q <= in_set;
                    else      skid_v <= 1'b0;
                end else if (push) begin
                    main_q <= in_set;
                end else begin
                    main_v <= 1'b0;
                end
            end else if (push) begin
                if (!main_v) begin
                    main_q <= in_set;
                    main_v <= 1'b1;
                end else begin
                    skid_q <= in_set;
                    skid_v <= 1'b1;
                end
            end
            if (push && in_set.tag && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign out_valid_o    = main_v;
    assign op_o           = main_q.op;
    assign p1_o           = main_q.p1;
    assign p2_o           = main_q.p2;
    assign p3_o           = main_q.p3;
    assign special_tag_o  = main_q.tag;
    assign special_bits_o = main_q.bits;
    assign special_cnt_o  = cnt_q;

endmodule

// File: tb/tb_operand_conditioner.sv
// Scoreboard bench for operand_conditioner (N=16, SKID=1) with directed vectors.
module tb_operand_conditioner;
    import ppu_pkg::*;

    localparam int N = 16;
    localparam int W = 3 + 4 * N + 1;

    logic         clk, rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    operation_e   op_in, op_out;
    logic [N-1:0] p1, p2, p3, p1_out, p2_out, p3_out, bits_out;
    logic         tag_out;
    logic [15:0]  cnt_out;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           fails  = 0;
    int           exp_cnt = 0;

    operand_conditioner #(.N(N), .SKID(1)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .op_i           (op_in),
        .p1_i           (p1),
        .p2_i           (p2),
        .p3_i           (p3),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .op_o           (op_out),
        .p1_o           (p1_out),
        .p2_o           (p2_out),
        .p3_o           (p3_out),
        .special_tag_o  (tag_out),
        .special_bits_o (bits_out),
        .special_cnt_o  (cnt_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // monitor: every presented set must equal the queue head; pop when taken
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output got=%h", {op_out, p1_out, p2_out, p3_out, tag_out, bits_out});
            end else begin
                if ({op_out, p1_out, p2_out, p3_out, tag_out, bits_out} !== exp_q[0]) begin
                    fails++;
                    $display("FAIL output_set got=%h expected=%h",
                             {op_out, p1_out, p2_out, p3_out, tag_out, bits_out}, exp_q[0]);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // driver: present one set, wait for acceptance, record the expected result
    task automatic send(input operation_e op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] c, input operation_e eop, input logic [N-1:0] e1,
                        input logic [N-1:0] e2, input logic etag, input logic [N-1:0] ebits);
        int waited = 0;
        in_valid = 1'b1;
        op_in    = op;
        p1       = a;
        p2       = b;
        p3       = c;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout op=%0d p1=%h p2=%h", op, a, b);
        end else begin
            exp_q.push_back({eop, e1, e2, c, etag, ebits});
            if (etag && exp_cnt < 65535) exp_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("drain_queue_empty", W'(exp_q.size()), W'(0));
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog_timeout");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_in     = OP_ADD;
        p1        = '0;
        p2        = '0;
        p3        = '0;
        #2;
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_cnt", W'(cnt_out), W'(0));
        check("reset_in_ready", W'(in_ready), W'(1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_release", W'(in_ready), W'(1));
        @(posedge clk);
        #1;

        // directed vectors, free-flowing output
        send(OP_ADD, 16'h3000, 16'h5000, 16'h0000, OP_ADD, 16'h5000, 16'h3000, 1'b0, 16'h0000);
        send(OP_SUB, 16'h4000, 16'h4000, 16'h0000, OP_ADD, 16'h4000, 16'hC000, 1'b1, 16'h0000);
        check("cnt_after_sub_zero", W'(cnt_out), W'(1));
        send(OP_FMA, 16'h0000, 16'h4000, 16'h2000, OP_FMA, 16'h0000, 16'h4000, 1'b1, 16'h2000);
        send(OP_FMA, 16'h0000, 16'h4000, 16'h8000, OP_FMA, 16'h0000, 16'h4000, 1'b1, 16'h8000);
        send(OP_SUB, 16'h1000, 16'h3000, 16'h0000, OP_ADD, 16'hD000, 16'h1000, 1'b0, 16'h0000);
        send(OP_DIV, 16'h4000, 16'h0000, 16'h0000, OP_DIV, 16'h4000, 16'h0000, 1'b1, 16'h8000);
        send(OP_MUL, 16'h8000, 16'h4000, 16'h0000, OP_MUL, 16'h8000, 16'h4000, 1'b1, 16'h8000);
        send(OP_MUL, 16'h4000, 16'h0000, 16'h0000, OP_MUL, 16'h4000, 16'h0000, 1'b1, 16'h0000);
        send(OP_ADD, 16'h0000, 16'h5000, 16'h0000, OP_ADD, 16'h5000, 16'h0000, 1'b1, 16'h5000);
        send(OP_SUB, 16'h0000, 16'h5000, 16'h0000, OP_ADD, 16'hB000, 16'h0000, 1'b1, 16'hB000);
        send(OP_ADD, 16'h2000, 16'h0000, 16'h0000, OP_ADD, 16'h2000, 16'h0000, 1'b1, 16'h2000);
        send(OP_ADD, 16'h3000, 16'hD000, 16'h0000, OP_ADD, 16'h3000, 16'hD000, 1'b1, 16'h0000);
        send(OP_F2P, 16'h8000, 16'h0000, 16'h0000, OP_F2P, 16'h8000, 16'h0000, 1'b0, 16'h0000);
        send(OP_SUB, 16'h1000, 16'h8000, 16'h0000, OP_ADD, 16'h8000, 16'h1000, 1'b1, 16'h8000);
        send(OP_MUL, 16'h2000, 16'h3000, 16'h0000, OP_MUL, 16'h2000, 16'h3000, 1'b0, 16'h0000);
        send(OP_DIV, 16'h0000, 16'h4000, 16'h0000, OP_DIV, 16'h0000, 16'h4000, 1'b1, 16'h0000);
        send(OP_ADD, 16'h1000, 16'h2000, 16'h8000, OP_ADD, 16'h2000, 16'h1000, 1'b0, 16'h0000);
        drain();
        check("cnt_after_directed", W'(cnt_out), W'(exp_cnt));

        // stall: two accepts fill main and skid, then ready must drop
        out_ready = 1'b0;
        send(OP_SUB, 16'h1000, 16'h3000, 16'h0000, OP_ADD, 16'hD000, 16'h1000, 1'b0, 16'h0000);
        send(OP_MUL, 16'h2000, 16'h3000, 16'h0000, OP_MUL, 16'h2000, 16'h3000, 1'b0, 16'h0000);
        in_valid = 1'b1;
        op_in    = OP_ADD;
        p1       = 16'h1000;
        p2       = 16'h2000;
        p3       = 16'h8000;
        @(negedge clk);
        check("in_ready_full_stalled", W'(in_ready), W'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(OP_ADD, 16'h1000, 16'h2000, 16'h8000, OP_ADD, 16'h2000, 16'h1000, 1'b0, 16'h0000);
        send(OP_ADD, 16'h3000, 16'h5000, 16'h0000, OP_ADD, 16'h5000, 16'h3000, 1'b0, 16'h0000);
        drain();

        // asynchronous reset with two sets held
        out_ready = 1'b0;
        send(OP_MUL, 16'h4000, 16'h0000, 16'h0000, OP_MUL, 16'h4000, 16'h0000, 1'b1, 16'h0000);
        send(OP_DIV, 16'h4000, 16'h0000, 16'h0000, OP_DIV, 16'h4000, 16'h0000, 1'b1, 16'h8000);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        exp_cnt = 0;
        check("async_reset_out_valid", W'(out_valid), W'(0));
        check("async_reset_cnt", W'(cnt_out), W'(0));
        check("async_reset_in_ready", W'(in_ready), W'(1));
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_after_reset", W'(out_valid), W'(0));
            check("in_ready_after_reset", W'(in_ready), W'(1));
        end
        @(posedge clk);
        #1;

        // saturation: 2^16 + 5 special transfers
        for (int i = 0; i < 65541; i++) begin
            send(OP_MUL, 16'h0000, 16'h4000, 16'h0000, OP_MUL, 16'h0000, 16'h4000, 1'b1, 16'h0000);
        end
        drain();
        check("cnt_saturated", W'(cnt_out), W'(16'hFFFF));
        check("cnt_model", W'(cnt_out), W'(exp_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
